// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO controller.
//   - Register word indices (byte address [5:2]) for the register map.
//   - LCKK bit position inside LCKR.
//   - Lock FSM state encoding.
//   - expand_pin_mask(): widens a per-pin mask to the 2-bit-per-pin fields.
// These definitions are also consumed by the driver-side header generator.
package gpio_pkg;

    // Word index of each register (byte address >> 2)
    localparam logic [3:0] REG_DIR   = 4'h0;  // 0x00
    localparam logic [3:0] REG_TYPE  = 4'h1;  // 0x04
    localparam logic [3:0] REG_SPEED = 4'h2;  // 0x08
    localparam logic [3:0] REG_PUPD  = 4'h3;  // 0x0C
    localparam logic [3:0] REG_IDR   = 4'h4;  // 0x10, read-only
    localparam logic [3:0] REG_ODR   = 4'h5;  // 0x14
    localparam logic [3:0] REG_BSRR  = 4'h6;  // 0x18, write-only
    localparam logic [3:0] REG_LCKR  = 4'h7;  // 0x1C
    localparam logic [3:0] REG_IMR   = 4'h8;  // 0x20
    localparam logic [3:0] REG_RTSR  = 4'h9;  // 0x24
    localparam logic [3:0] REG_FTSR  = 4'hA;  // 0x28
    localparam logic [3:0] REG_PR    = 4'hB;  // 0x2C, write-1-to-clear

    localparam int unsigned LCKK_BIT = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StKey1   = 3'd1,
        StKey2   = 3'd2,
        StKey3   = 3'd3,
        StLocked = 3'd4
    } lock_state_e;

    // Pin i of the result covers bits [2i+1:2i].
    function automatic logic [31:0] expand_pin_mask(input logic [15:0] pin_mask);
        logic [31:0] wide;
        wide = '0;
        for (int i = 0; i < 16; i++) begin
            wide[2*i]   = pin_mask[i];
            wide[2*i+1] = pin_mask[i];
        end
        return wide;
    endfunction

endpackage

// File: rtl/gpio_lock_fsm.sv
// gpio_lock_fsm: key-sequence configuration lock.
//   Sequence: write LCKK=1/M, write LCKK=0/M, write LCKK=1/M, read LCKR -> locked.
//   Only reset leaves the locked state. The mask is captured on entry to locked.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   lckr_wr      write strobe addressed to LCKR
//   lckr_rd      read strobe addressed to LCKR
//   other_acc    any read or write to a register other than LCKR
//   key_word     LCKR write data bits [16:0] (LCKK, M)
//   lock_mask    captured per-pin lock mask (0 until locked)
//   locked       high once the sequence has completed
module gpio_lock_fsm
    import gpio_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        lckr_wr,
    input  logic        lckr_rd,
    input  logic        other_acc,
    input  logic [16:0] key_word,
    output logic [15:0] lock_mask,
    output logic        locked
);

    lock_state_e state_q;
    logic [15:0] key_q;
    logic        lckk;
    logic [15:0] key_m;
    logic        key_match;

    assign lckk      = key_word[LCKK_BIT];
    assign key_m     = key_word[15:0];
    assign key_match = (key_m == key_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            key_q     <= '0;
            lock_mask <= '0;
            locked    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (lckr_wr && lckk) begin
                        state_q <= StKey1;
                        key_q   <= key_m;
                    end
                end
                StKey1, StKey2: begin
                    if (other_acc) begin
                        state_q <= StIdle;
                    end else if (lckr_wr) begin
                        // Expected key bit alternates: K1 wants LCKK=0, K2 wants LCKK=1.
                        if ((state_q == StKey1) && !lckk && key_match) begin
                            state_q <= StKey2;
                        end else if ((state_q == StKey2) && lckk && key_match) begin
                            state_q <= StKey3;
                        end else if (lckk) begin
                            // Any other LCKK=1 write starts a fresh sequence.
                            state_q <= StKey1;
                            key_q   <= key_m;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (lckr_rd) begin
                        state_q <= StIdle;
                    end
                end
                StKey3: begin
                    if (other_acc) begin
                        state_q <= StIdle;
                    end else if (lckr_wr) begin
                        if (lckk) begin
                            state_q <= StKey1;
                            key_q   <= key_m;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (lckr_rd) begin
                        state_q   <= StLocked;
                        lock_mask <= key_q;
                        locked    <= 1'b1;
                    end
                end
                StLocked: begin
                    state_q <= StLocked;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped controller for the 16-pin GPIO pad ring.
//   Pin configuration (DIR/TYPE/SPEED/PUPD), output data with atomic set/reset,
//   synchronised input, edge-triggered interrupts and a key-sequence config lock.
// Configuration macro: GPIO_CTRL_IRQ_EN enables IMR/RTSR/FTSR/PR and edge detect;
//   when undefined those addresses read 0, writes are ignored and gpio_irq is 0.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   reg_wr, reg_rd         single-cycle register strobes
//   reg_addr, reg_wdata    byte address (word aligned) and write data
//   reg_rdata              registered read data, valid the cycle after reg_rd
//   r_type, r_pupd, r_speed  pad configuration
//   gpio_dir, gpio_out     pad output enable and output value
//   gpio_in                raw asynchronous pad input
//   gpio_irq               registered level interrupt, |(PR & IMR)
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] RST_DIR     = 16'h0000,
    parameter logic [31:0] RST_PUPD    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [5:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic [15:0] r_type,
    output logic [31:0] r_pupd,
    output logic [31:0] r_speed,
    output logic [15:0] gpio_dir,
    output logic [15:0] gpio_out,
    input  logic [15:0] gpio_in,
    output logic        gpio_irq
);

    logic [3:0]  reg_idx;
    logic        unused_addr;
    logic [15:0] lock_mask;
    logic [31:0] lock_mask_wide;
    logic        locked;

    logic [15:0] dir_q, dir_d;
    logic [15:0] type_q, type_d;
    logic [31:0] speed_q, speed_d;
    logic [31:0] pupd_q, pupd_d;
    logic [15:0] odr_q, odr_d;
    logic [31:0] rdata_q, rdata_d;

    logic [SYNC_STAGES-1:0][15:0] sync_q;
    logic [15:0] idr;

    assign reg_idx     = reg_addr[5:2];
    assign unused_addr = ^reg_addr[1:0];

    // ---------------------------------------------------------------- lock
    gpio_lock_fsm u_lock_fsm (
        .clk       (clk),
        .rst       (rst),
        .lckr_wr   (reg_wr && (reg_idx == REG_LCKR)),
        .lckr_rd   (reg_rd && (reg_idx == REG_LCKR)),
        .other_acc ((reg_wr || reg_rd) && (reg_idx != REG_LCKR)),
        .key_word  (reg_wdata[16:0]),
        .lock_mask (lock_mask),
        .locked    (locked)
    );

    assign lock_mask_wide = expand_pin_mask(lock_mask);

    // ------------------------------------------------------- input sync
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
        end
    end

    assign idr = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------- config regs
    // Locked bits keep their current value; unlocked bits of the same write apply.
    always_comb begin
        dir_d   = dir_q;
        type_d  = type_q;
        speed_d = speed_q;
        pupd_d  = pupd_q;
        odr_d   = odr_q;
        if (reg_wr) begin
            case (reg_idx)
                REG_DIR:   dir_d   = (dir_q & lock_mask) | (reg_wdata[15:0] & ~lock_mask);
                REG_TYPE:  type_d  = (type_q & lock_mask) | (reg_wdata[15:0] & ~lock_mask);
                REG_SPEED: speed_d = (speed_q & lock_mask_wide) | (reg_wdata & ~lock_mask_wide);
                REG_PUPD:  pupd_d  = (pupd_q & lock_mask_wide) | (reg_wdata & ~lock_mask_wide);
                REG_ODR:   odr_d   = reg_wdata[15:0];
                // Set is applied after clear so set wins on a conflicting pin.
                REG_BSRR:  odr_d   = (odr_q & ~reg_wdata[31:16]) | reg_wdata[15:0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q   <= RST_DIR;
            type_q  <= '0;
            speed_q <= '0;
            pupd_q  <= RST_PUPD;
            odr_q   <= '0;
        end else begin
            dir_q   <= dir_d;
            type_q  <= type_d;
            speed_q <= speed_d;
            pupd_q  <= pupd_d;
            odr_q   <= odr_d;
        end
    end

    assign gpio_dir = dir_q;
    assign r_type   = type_q;
    assign r_speed  = speed_q;
    assign r_pupd   = pupd_q;
    assign gpio_out = odr_q;

    // ------------------------------------------------------- interrupts
`ifdef GPIO_CTRL_IRQ_EN
    logic [15:0] imr_q, imr_d;
    logic [15:0] rtsr_q, rtsr_d;
    logic [15:0] ftsr_q, ftsr_d;
    logic [15:0] pr_q, pr_d;
    logic [15:0] idr_prev_q;
    logic [15:0] rise, fall;
    logic        irq_q;

    assign rise = idr & ~idr_prev_q;
    assign fall = ~idr & idr_prev_q;

    always_comb begin
        imr_d  = imr_q;
        rtsr_d = rtsr_q;
        ftsr_d = ftsr_q;
        pr_d   = pr_q;
        if (reg_wr) begin
            case (reg_idx)
                REG_IMR:  imr_d  = reg_wdata[15:0];
                REG_RTSR: rtsr_d = reg_wdata[15:0];
                REG_FTSR: ftsr_d = reg_wdata[15:0];
                REG_PR:   pr_d   = pr_q & ~reg_wdata[15:0];
                default:  ;
            endcase
        end
        // OR-ing the set term last makes a same-cycle edge beat the clear.
        pr_d = pr_d | (rise & rtsr_q) | (fall & ftsr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imr_q      <= '0;
            rtsr_q     <= '0;
            ftsr_q     <= '0;
            pr_q       <= '0;
            idr_prev_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            imr_q      <= imr_d;
            rtsr_q     <= rtsr_d;
            ftsr_q     <= ftsr_d;
            pr_q       <= pr_d;
            idr_prev_q <= idr;
            irq_q      <= |(pr_q & imr_q);
        end
    end

    assign gpio_irq = irq_q;
`else
    assign gpio_irq = 1'b0;
`endif

    // ------------------------------------------------------- read path
    // Mux uses pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rdata_d = '0;
        case (reg_idx)
            REG_DIR:   rdata_d = {16'h0, dir_q};
            REG_TYPE:  rdata_d = {16'h0, type_q};
            REG_SPEED: rdata_d = speed_q;
            REG_PUPD:  rdata_d = pupd_q;
            REG_IDR:   rdata_d = {16'h0, idr};
            REG_ODR:   rdata_d = {16'h0, odr_q};
            REG_LCKR:  rdata_d = {15'h0, locked, lock_mask};
`ifdef GPIO_CTRL_IRQ_EN
            REG_IMR:   rdata_d = {16'h0, imr_q};
            REG_RTSR:  rdata_d = {16'h0, rtsr_q};
            REG_FTSR:  rdata_d = {16'h0, ftsr_q};
            REG_PR:    rdata_d = {16'h0, pr_q};
`endif
            default:   rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (reg_rd) begin
            rdata_q <= rdata_d;
        end
    end

    assign reg_rdata = rdata_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: read tasks queue the expected word, and a
// monitor compares reg_rdata on the cycle after each read strobe.
module tb_gpio_ctrl;

    localparam int unsigned SYNC     = 3;
    localparam logic [15:0] RST_DIR  = 16'h00FF;
    localparam logic [31:0] RST_PUPD = 32'h5555_0000;

    logic        clk;
    logic        rst;
    logic        reg_wr;
    logic        reg_rd;
    logic [5:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic [15:0] r_type;
    logic [31:0] r_pupd;
    logic [31:0] r_speed;
    logic [15:0] gpio_dir;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in;
    logic        gpio_irq;

    gpio_ctrl #(
        .SYNC_STAGES (SYNC),
        .RST_DIR     (RST_DIR),
        .RST_PUPD    (RST_PUPD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .r_type    (r_type),
        .r_pupd    (r_pupd),
        .r_speed   (r_speed),
        .gpio_dir  (gpio_dir),
        .gpio_out  (gpio_out),
        .gpio_in   (gpio_in),
        .gpio_irq  (gpio_irq)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic rd_pend;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Tasks are entered at a negedge and return at the following negedge.
    task automatic rd(input logic [5:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.name    = name;
        e.val     = exp;
        exp_q.push_back(e);
        reg_addr  = addr;
        reg_rd    = 1'b1;
        @(negedge clk);
        reg_rd    = 1'b0;
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data);
        reg_addr  = addr;
        reg_wdata = data;
        reg_wr    = 1'b1;
        @(negedge clk);
        reg_wr    = 1'b0;
    endtask

    task automatic rw(input logic [5:0] addr, input logic [31:0] data,
                      input logic [31:0] exp, input string name);
        exp_t e;
        e.name    = name;
        e.val     = exp;
        exp_q.push_back(e);
        reg_addr  = addr;
        reg_wdata = data;
        reg_wr    = 1'b1;
        reg_rd    = 1'b1;
        @(negedge clk);
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
    endtask

    always @(posedge clk) rd_pend <= reg_rd && !rst;

    // Monitor: one expected entry per completed read.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %08h, expected no read data", reg_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, reg_rdata, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        gpio_in   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("irq_rst", {31'h0, gpio_irq}, 32'h0);
        check("dir_pin_rst", {16'h0, gpio_dir}, {16'h0, RST_DIR});
        check("pupd_pin_rst", r_pupd, RST_PUPD);
        check("rdata_rst", reg_rdata, 32'h0);
        rd(6'h00, {16'h0, RST_DIR}, "dir_rst");
        rd(6'h04, 32'h0, "type_rst");
        rd(6'h08, 32'h0, "speed_rst");
        rd(6'h0C, RST_PUPD, "pupd_rst");
        rd(6'h10, 32'h0, "idr_rst");
        rd(6'h14, 32'h0, "odr_rst");
        rd(6'h18, 32'h0, "bsrr_rst");
        rd(6'h1C, 32'h0, "lckr_rst");
        rd(6'h20, 32'h0, "imr_rst");
        rd(6'h24, 32'h0, "rtsr_rst");
        rd(6'h28, 32'h0, "ftsr_rst");
        rd(6'h2C, 32'h0, "pr_rst");
        rd(6'h30, 32'h0, "unmapped_rst");

        // ODR and BSRR
        wr(6'h14, 32'h0000_00F0);
        wr(6'h18, 32'h0001_0003);
        rd(6'h14, 32'h0000_00F3, "odr_bsrr_set_wins");
        check("gpio_out_f3", {16'h0, gpio_out}, 32'h0000_00F3);
        wr(6'h18, 32'h00F0_0000);
        rd(6'h14, 32'h0000_0003, "odr_bsrr_clr");
        rd(6'h18, 32'h0, "bsrr_reads_zero");
        rw(6'h14, 32'h0000_1234, 32'h0000_0003, "rw_same_addr_old");
        rd(6'h14, 32'h0000_1234, "odr_after_rw");
        wr(6'h30, 32'hFFFF_FFFF);
        rd(6'h30, 32'h0, "unmapped_wr");

        // Input synchroniser latency
        gpio_in = 16'hA5A5;
        for (int k = 0; k <= int'(SYNC); k++) begin
            rd(6'h10, (k < int'(SYNC)) ? 32'h0 : 32'h0000_A5A5, $sformatf("idr_k%0d", k));
        end

`ifdef GPIO_CTRL_IRQ_EN
        gpio_in = 16'h0000;
        repeat (6) @(negedge clk);
        wr(6'h24, 32'h1);
        wr(6'h20, 32'h1);
        rd(6'h2C, 32'h0, "pr_idle");
        gpio_in = 16'h0001;
        repeat (6) @(negedge clk);
        rd(6'h2C, 32'h1, "pr_rise");
        check("irq_rise", {31'h0, gpio_irq}, 32'h1);

        // Clear lands on the same edge that a new rising edge sets PR.
        gpio_in = 16'h0000;
        repeat (6) @(negedge clk);
        gpio_in = 16'h0001;
        repeat (SYNC) @(negedge clk);
        wr(6'h2C, 32'h1);
        rd(6'h2C, 32'h1, "pr_set_wins");

        wr(6'h2C, 32'h1);
        check("irq_hold_one_cycle", {31'h0, gpio_irq}, 32'h1);
        @(negedge clk);
        check("irq_cleared", {31'h0, gpio_irq}, 32'h0);
        rd(6'h2C, 32'h0, "pr_cleared");

        wr(6'h28, 32'h1);
        gpio_in = 16'h0000;
        repeat (6) @(negedge clk);
        rd(6'h2C, 32'h1, "pr_fall");
`else
        wr(6'h20, 32'hFFFF_FFFF);
        wr(6'h24, 32'hFFFF_FFFF);
        wr(6'h28, 32'hFFFF_FFFF);
        wr(6'h2C, 32'hFFFF_FFFF);
        rd(6'h20, 32'h0, "imr_absent");
        rd(6'h24, 32'h0, "rtsr_absent");
        rd(6'h28, 32'h0, "ftsr_absent");
        rd(6'h2C, 32'h0, "pr_absent");
        gpio_in = 16'h0000;
        repeat (6) @(negedge clk);
        check("irq_absent", {31'h0, gpio_irq}, 32'h0);
`endif

        // Reset while the lock FSM sits in K2
        wr(6'h00, 32'h0000_0F0F);
        wr(6'h04, 32'h0000_00FF);
        wr(6'h08, 32'hAAAA_AAAA);
        rd(6'h08, 32'hAAAA_AAAA, "speed_wr");
        wr(6'h1C, 32'h0001_0003);
        wr(6'h1C, 32'h0000_0003);
        rst = 1'b1;
        #1;
        check("async_rst_dir", {16'h0, gpio_dir}, {16'h0, RST_DIR});
        check("async_rst_type", {16'h0, r_type}, 32'h0);
        check("async_rst_speed", r_speed, 32'h0);
        check("async_rst_pupd", r_pupd, RST_PUPD);
        check("async_rst_out", {16'h0, gpio_out}, 32'h0);
        check("async_rst_irq", {31'h0, gpio_irq}, 32'h0);
        check("async_rst_rdata", reg_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd(6'h2C, 32'h0, "pr_after_rst");
        // From K2 this would complete a lock; from IDLE it only reaches K1.
        wr(6'h1C, 32'h0001_0003);
        rd(6'h1C, 32'h0, "lckr_after_rst_a");
        rd(6'h1C, 32'h0, "lckr_after_rst_b");

        // Broken sequence: wrong M at step 2
        wr(6'h1C, 32'h0001_000F);
        wr(6'h1C, 32'h0000_0003);
        wr(6'h1C, 32'h0001_000F);
        rd(6'h1C, 32'h0, "lckr_broken_a");
        rd(6'h1C, 32'h0, "lckr_broken_b");
        wr(6'h00, 32'h0000_FFFF);
        rd(6'h00, 32'h0000_FFFF, "dir_after_broken");

        // Valid sequence with M=000F
        wr(6'h00, 32'h0);
        wr(6'h1C, 32'h0001_000F);
        wr(6'h1C, 32'h0000_000F);
        wr(6'h1C, 32'h0001_000F);
        rd(6'h1C, 32'h0, "lckr_final_read_old");
        rd(6'h1C, 32'h0001_000F, "lckr_locked");
        wr(6'h00, 32'h0000_FFFF);
        rd(6'h00, 32'h0000_FFF0, "dir_locked");
        check("gpio_dir_locked", {16'h0, gpio_dir}, 32'h0000_FFF0);
        wr(6'h0C, 32'hFFFF_FFFF);
        rd(6'h0C, 32'hFFFF_FF00, "pupd_locked");
        wr(6'h14, 32'h0000_FFFF);
        rd(6'h14, 32'h0000_FFFF, "odr_never_locked");
        wr(6'h1C, 32'h0);
        rd(6'h1C, 32'h0001_000F, "lckr_sticky");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
